// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one external memory port among CHANNELS requesters.
// Registered strobes and response pulses, with an optional BUSY timeout abort.
module memory_arbiter #(
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [CHANNELS-1:0]              ch_read,
    input  logic [CHANNELS-1:0]              ch_write,
    input  logic [CHANNELS*ADDR_WIDTH-1:0]   ch_address,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   ch_wdata,
    output logic [DATA_WIDTH-1:0]            ch_rdata,
    output logic [CHANNELS-1:0]              ch_ready,
    output logic [CHANNELS-1:0]              ch_done,
    output logic [CHANNELS-1:0]              ch_error,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic                             mem_read,
    output logic                             mem_write,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_ready,
    input  logic                             mem_done
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

    state_t                state, state_next;
    logic [IW-1:0]         last, last_next;
    logic [IW-1:0]         grant, grant_next;
    logic                  is_read, is_read_next;
    logic [ADDR_WIDTH-1:0] addr, addr_next;
    logic [DATA_WIDTH-1:0] wdata, wdata_next;
    logic [DATA_WIDTH-1:0] rdata, rdata_next;
    logic [CW-1:0]         count, count_next, count_inc;
    logic                  rd_strobe, rd_strobe_next;
    logic                  wr_strobe, wr_strobe_next;
    logic [CHANNELS-1:0]   ready, ready_next;
    logic [CHANNELS-1:0]   done, done_next;
    logic [CHANNELS-1:0]   error, error_next;
    logic [CHANNELS-1:0]   pending;
    logic                  found;
    int                    pick;
    int                    cand;

    assign pending   = ch_read | ch_write;
    assign count_inc = count + CW'(1);

    always_comb begin
        state_next   = state;
        last_next    = last;
        grant_next   = grant;
        is_read_next = is_read;
        addr_next    = addr;
        wdata_next   = wdata;
        rdata_next   = rdata;
        count_next   = count;
        ready_next   = '0;
        done_next    = '0;
        error_next   = '0;
        found        = 1'b0;
        pick         = 0;
        cand         = 0;
        unique case (state)
            IDLE: begin
                // Walk backwards so the last hit is the first after last grant.
                for (int k = CHANNELS; k >= 1; k--) begin
                    cand = (int'(last) + k) % CHANNELS;
                    if (pending[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end
                end
                if (found) begin
                    grant_next   = IW'(pick);
                    last_next    = IW'(pick);
                    addr_next    = ch_address[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_next   = ch_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
                    is_read_next = ch_read[pick];
                    count_next   = '0;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (is_read && mem_ready) begin
                    rdata_next        = mem_rdata;
                    ready_next[grant] = 1'b1;
                    state_next        = RESPOND;
                end else if (!is_read && mem_done) begin
                    done_next[grant] = 1'b1;
                    state_next       = RESPOND;
                end else if (TIMEOUT != 0) begin
                    if (count_inc == CW'(TIMEOUT)) begin
                        error_next[grant] = 1'b1;
                        state_next        = RESPOND;
                    end else begin
                        count_next = count_inc;
                    end
                end
            end
            RESPOND: begin
                count_next = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        rd_strobe_next = (state_next == BUSY) && is_read_next;
        wr_strobe_next = (state_next == BUSY) && !is_read_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= IW'(CHANNELS - 1);
            grant     <= '0;
            is_read   <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rdata     <= '0;
            count     <= '0;
            rd_strobe <= 1'b0;
            wr_strobe <= 1'b0;
            ready     <= '0;
            done      <= '0;
            error     <= '0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            grant     <= grant_next;
            is_read   <= is_read_next;
            addr      <= addr_next;
            wdata     <= wdata_next;
            rdata     <= rdata_next;
            count     <= count_next;
            rd_strobe <= rd_strobe_next;
            wr_strobe <= wr_strobe_next;
            ready     <= ready_next;
            done      <= done_next;
            error     <= error_next;
        end
    end

    assign mem_address = addr;
    assign mem_wdata   = wdata;
    assign mem_read    = rd_strobe;
    assign mem_write   = wr_strobe;
    assign ch_rdata    = rdata;
    assign ch_ready    = ready;
    assign ch_done     = done;
    assign ch_error    = error;

endmodule
